// File: rtl/pll_cfg_master.sv
// Avalon-MM configuration master for a PLL: boots the control register after the
// PLL leaves reset, then forwards single read/write commands with a stall timeout.
module pll_cfg_master #(
  parameter logic [15:0] INIT_CTRL = 16'h0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pll_resetrequest,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        read,
  output logic        write,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  input  logic        waitrequest,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        init_done,
  output logic        init_error
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    INIT_WR,
    INIT_RD,
    IDLE,
    BUS_WR,
    BUS_RD,
    RESP
  } state_t;

  localparam logic [7:0] LAST_STALL = 8'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic [2:0]  address_d;
  logic        chipselect_d, read_d, write_d;
  logic [15:0] writedata_d;
  logic        cmd_ready_d, rsp_valid_d, rsp_error_d;
  logic [15:0] rsp_data_d;
  logic        init_done_d, init_error_d;
  logic        timeout_hit;

  // The stall that brings the counter up to TIMEOUT aborts the access.
  assign timeout_hit = waitrequest && (cnt == LAST_STALL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      address    <= '0;
      chipselect <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      address    <= address_d;
      chipselect <= chipselect_d;
      read       <= read_d;
      write      <= write_d;
      writedata  <= writedata_d;
      cmd_ready  <= cmd_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_error  <= rsp_error_d;
      init_done  <= init_done_d;
      init_error <= init_error_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    address_d    = address;
    chipselect_d = chipselect;
    read_d       = read;
    write_d      = write;
    writedata_d  = writedata;
    cmd_ready_d  = cmd_ready;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data;
    rsp_error_d  = rsp_error;
    init_done_d  = init_done;
    init_error_d = init_error;

    case (state)
      WAIT_LOCK: begin
        if (!pll_resetrequest) begin
          state_d      = INIT_WR;
          cnt_d        = '0;
          address_d    = 3'd1;
          chipselect_d = 1'b1;
          write_d      = 1'b1;
          writedata_d  = INIT_CTRL;
        end
      end

      INIT_WR, INIT_RD: begin
        if (!waitrequest) begin
          if (state == INIT_WR) begin
            state_d = INIT_RD;
            cnt_d   = '0;
            write_d = 1'b0;
            read_d  = 1'b1;
          end else begin
            state_d      = IDLE;
            read_d       = 1'b0;
            chipselect_d = 1'b0;
            cmd_ready_d  = 1'b1;
            init_done_d  = 1'b1;
            init_error_d = init_error | (readdata != INIT_CTRL);
          end
        end else begin
          cnt_d = cnt + 8'd1;
          if (timeout_hit) begin
            state_d      = IDLE;
            read_d       = 1'b0;
            write_d      = 1'b0;
            chipselect_d = 1'b0;
            cmd_ready_d  = 1'b1;
            init_done_d  = 1'b1;
            init_error_d = 1'b1;
          end
        end
      end

      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d      = cmd_write ? BUS_WR : BUS_RD;
          cnt_d        = '0;
          cmd_ready_d  = 1'b0;
          address_d    = cmd_addr;
          chipselect_d = 1'b1;
          write_d      = cmd_write;
          read_d       = !cmd_write;
          if (cmd_write) writedata_d = cmd_wdata;
        end
      end

      BUS_WR, BUS_RD: begin
        if (!waitrequest || timeout_hit) begin
          state_d      = RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          chipselect_d = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_error_d  = waitrequest;
          rsp_data_d   = (state == BUS_RD && !waitrequest) ? readdata : '0;
        end
        if (waitrequest) cnt_d = cnt + 8'd1;
      end

      RESP: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end

      default: state_d = WAIT_LOCK;
    endcase
  end

endmodule

// File: tb/tb_pll_cfg_master.sv
// Self-checking bench for pll_cfg_master: scripted and random accesses against a
// cycle-count/response model derived from the stall and timeout rules.
module tb_pll_cfg_master;

  localparam logic [15:0] INIT = 16'h0002;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pll_resetrequest = 1'b1;
  logic [2:0]  address;
  logic        chipselect, read, write;
  logic [15:0] writedata;
  logic [15:0] readdata = '0;
  logic        waitrequest = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic        init_done, init_error;

  int n_checks = 0;
  int n_fail = 0;

  int acc_cycles;
  logic acc_rsp, acc_both;
  logic [15:0] last_wdata;

  pll_cfg_master #(.INIT_CTRL(INIT), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .pll_resetrequest(pll_resetrequest),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .init_done(init_done),
    .init_error(init_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave side: stalls the given number of cycles while the selected strobe is high.
  task automatic run_access(input logic want_rd, input int stalls, input logic [15:0] rd);
    acc_cycles = 0;
    acc_rsp = 1'b0;
    acc_both = 1'b0;
    while ((want_rd ? read : write) && acc_cycles < 300) begin
      acc_cycles++;
      if (rsp_valid) acc_rsp = 1'b1;
      if (read && write) acc_both = 1'b1;
      waitrequest = (acc_cycles <= stalls);
      readdata = rd;
      tick();
    end
    waitrequest = 1'b0;
  endtask

  function automatic int exp_cycles(input int stalls);
    return (stalls >= TO) ? TO : stalls + 1;
  endfunction

  task automatic do_boot(input int wr_stalls, input int rd_stalls, input logic [15:0] rdval,
                         input int lock_cycles);
    int bad;
    logic exp_err;
    reset_n = 1'b0;
    pll_resetrequest = 1'b1;
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < lock_cycles; i++) begin
      tick();
      if (read || write || chipselect || cmd_ready) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL boot_wait_lock: bus active %0d cycles, required 0", bad); end
    pll_resetrequest = 1'b0;
    tick();
    n_checks++;
    if ({write, read, chipselect, address, writedata} !== {1'b1, 1'b0, 1'b1, 3'd1, INIT}) begin
      n_fail++;
      $display("FAIL boot_init_wr: wr=%0b rd=%0b cs=%0b addr=%0d wdata=%h, required 1 0 1 1 %h",
               write, read, chipselect, address, writedata, INIT);
    end
    run_access(1'b0, wr_stalls, rdval);
    n_checks++;
    if (acc_cycles !== exp_cycles(wr_stalls) || acc_rsp || acc_both) begin
      n_fail++;
      $display("FAIL boot_wr_len: cycles=%0d rsp=%0b both=%0b, required %0d 0 0",
               acc_cycles, acc_rsp, acc_both, exp_cycles(wr_stalls));
    end
    exp_err = (wr_stalls >= TO);
    if (!exp_err) begin
      n_checks++;
      if ({read, chipselect, address} !== {1'b1, 1'b1, 3'd1}) begin
        n_fail++;
        $display("FAIL boot_init_rd: rd=%0b cs=%0b addr=%0d, required 1 1 1", read, chipselect, address);
      end
      run_access(1'b1, rd_stalls, rdval);
      n_checks++;
      if (acc_cycles !== exp_cycles(rd_stalls) || acc_rsp || acc_both) begin
        n_fail++;
        $display("FAIL boot_rd_len: cycles=%0d rsp=%0b both=%0b, required %0d 0 0",
                 acc_cycles, acc_rsp, acc_both, exp_cycles(rd_stalls));
      end
      exp_err = (rd_stalls >= TO) || (rdval != INIT);
    end
    n_checks++;
    if ({init_done, init_error, cmd_ready, read, write, chipselect, rsp_valid} !==
        {1'b1, exp_err, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL boot_status: done=%0b err=%0b ready=%0b rd=%0b wr=%0b cs=%0b rsp=%0b, required 1 %0b 1 0 0 0 0",
               init_done, init_error, cmd_ready, read, write, chipselect, rsp_valid, exp_err);
    end
    last_wdata = INIT;
  endtask

  task automatic do_cmd(input logic is_wr, input logic [2:0] a, input logic [15:0] wd,
                        input int stalls, input logic [15:0] rdval);
    int n;
    logic exp_err;
    logic [15:0] exp_data, exp_wd;
    n = 0;
    while (!cmd_ready && n < 10) begin tick(); n++; end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_wait: ready=%0b, required 1", cmd_ready); end
    cmd_valid = 1'b1;
    cmd_write = is_wr;
    cmd_addr = a;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
    cmd_wdata = ~wd;
    cmd_addr = ~a;
    exp_wd = is_wr ? wd : last_wdata;
    n_checks++;
    if ({write, read, chipselect, address, writedata, cmd_ready} !== {is_wr, !is_wr, 1'b1, a, exp_wd, 1'b0}) begin
      n_fail++;
      $display("FAIL cmd_start: wr=%0b rd=%0b cs=%0b addr=%0d wdata=%h ready=%0b, required %0b %0b 1 %0d %h 0",
               write, read, chipselect, address, writedata, cmd_ready, is_wr, !is_wr, a, exp_wd);
    end
    if (is_wr) last_wdata = wd;
    run_access(!is_wr, stalls, rdval);
    exp_err = (stalls >= TO);
    exp_data = (exp_err || is_wr) ? 16'h0000 : rdval;
    n_checks++;
    if (acc_cycles !== exp_cycles(stalls) || acc_rsp || acc_both) begin
      n_fail++;
      $display("FAIL cmd_len: cycles=%0d rsp=%0b both=%0b, required %0d 0 0",
               acc_cycles, acc_rsp, acc_both, exp_cycles(stalls));
    end
    n_checks++;
    if ({rsp_valid, rsp_error, rsp_data, read, write, chipselect} !== {1'b1, exp_err, exp_data, 3'b000}) begin
      n_fail++;
      $display("FAIL cmd_rsp: valid=%0b err=%0b data=%h rd=%0b wr=%0b cs=%0b, required 1 %0b %h 0 0 0",
               rsp_valid, rsp_error, rsp_data, read, write, chipselect, exp_err, exp_data);
    end
    tick();
    n_checks++;
    if ({rsp_valid, cmd_ready, rsp_data} !== {1'b0, 1'b1, exp_data}) begin
      n_fail++;
      $display("FAIL cmd_after: valid=%0b ready=%0b data=%h, required 0 1 %h", rsp_valid, cmd_ready, rsp_data, exp_data);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_checks++;
    if ({address, chipselect, read, write, writedata, cmd_ready, rsp_valid, rsp_data, rsp_error, init_done, init_error} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%0d cs=%0b rd=%0b wr=%0b wd=%h rdy=%0b rv=%0b rd=%h re=%0b done=%0b ierr=%0b, required all 0",
               address, chipselect, read, write, writedata, cmd_ready, rsp_valid, rsp_data, rsp_error, init_done, init_error);
    end
  endtask

  task automatic test_boot();
    do_boot(0, 0, INIT, 64);
    do_boot(0, 0, 16'h0000, 3);
    do_boot(2, 3, INIT, 5);
    do_boot(TO - 1, TO - 1, INIT, 2);
    do_boot(50, 0, INIT, 2);
    do_boot(0, 50, INIT, 2);
  endtask

  task automatic test_read_stall();
    do_boot(0, 0, INIT, 4);
    do_cmd(1'b0, 3'd0, 16'h0000, 3, 16'h0001);
  endtask

  task automatic test_write_timeout();
    do_cmd(1'b1, 3'd1, 16'hA5A5, 100, 16'hFFFF);
    do_cmd(1'b0, 3'd2, 16'h0000, TO - 1, 16'h1234);
    do_cmd(1'b0, 3'd3, 16'h0000, TO, 16'h4321);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      pll_resetrequest = $urandom_range(0, 1);
      do_cmd($urandom_range(0, 1), 3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 6), 16'($urandom));
    end
    n_checks++;
    if ({init_done, init_error} !== 2'b10) begin
      n_fail++;
      $display("FAIL boot_status_kept: done=%0b err=%0b, required 1 0", init_done, init_error);
    end
    pll_resetrequest = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    int bad;
    int n;
    n = 0;
    while (!cmd_ready && n < 10) begin tick(); n++; end
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 3'd5;
    tick();
    cmd_valid = 1'b0;
    waitrequest = 1'b1;
    tick();
    tick();
    pll_resetrequest = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({read, write, chipselect, rsp_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_access: rd=%0b wr=%0b cs=%0b rsp=%0b, required 0 0 0 0", read, write, chipselect, rsp_valid);
    end
    waitrequest = 1'b0;
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (read || write || chipselect || rsp_valid || cmd_ready || init_done) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL reset_wait_lock: active %0d cycles, required 0", bad); end
    do_boot(1, 1, INIT, 3);
    do_cmd(1'b1, 3'd6, 16'h5A5A, 0, 16'h0000);
  endtask

  initial begin
    last_wdata = '0;
    test_reset();
    test_boot();
    test_read_stall();
    test_write_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
